// File: rtl/param_rr_arbiter.sv
// param_rr_arbiter: N-requester registered arbiter with a one-hot grant.
// The mode input selects the policy at run time: fixed priority, round robin,
// or weighted round robin (WRR) with per-requester burst weights.
// The grant is registered, so no combinational path runs from req to grant.
// Optional macro ARB_LOCK_EN adds a 'lock' input. While lock is high and the
// owner keeps requesting, the current grant is held and its credit is frozen.
module param_rr_arbiter #(
  parameter int N        = 4,
  parameter int WEIGHT_W = 3,
  parameter int ID_W     = $clog2(N)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            mode,
  input  logic [N-1:0]          req,
  input  logic [N*WEIGHT_W-1:0] weights,
`ifdef ARB_LOCK_EN
  input  logic                  lock,
`endif
  output logic [N-1:0]          grant,
  output logic                  grant_valid,
  output logic [ID_W-1:0]       grant_id
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t                state_q, state_d;
  logic [N-1:0]          grant_q, grant_d;
  logic                  grant_valid_q, grant_valid_d;
  logic [ID_W-1:0]       grant_id_q, grant_id_d;
  logic [ID_W-1:0]       rr_ptr_q, rr_ptr_d;
  logic [WEIGHT_W-1:0]   credit_q, credit_d;

  logic [ID_W-1:0]       fixed_winner;
  logic [ID_W-1:0]       rr_winner;
  logic [ID_W-1:0]       winner;
  logic [N-1:0]          winner_onehot;
  logic [WEIGHT_W-1:0]   winner_weight;
  int                    rr_dist;
  int                    rr_best;
  logic                  is_fixed;
  logic                  is_wrr;
  logic                  owner_req;
  logic                  lock_hold;
  logic                  hold_end;
  logic                  arbitrate;

  // Fixed priority: scanning upward means the highest set index is the last one kept
  always_comb begin
    fixed_winner = '0;
    for (int i = 0; i < N; i++) begin
      if (req[i]) begin
        fixed_winner = ID_W'(i);
      end
    end
  end

  // Round robin: pick the requester at the smallest circular distance past rr_ptr
  always_comb begin
    rr_winner = '0;
    rr_best   = N;
    rr_dist   = 0;
    for (int j = 0; j < N; j++) begin
      rr_dist = j - int'(rr_ptr_q) - 1;
      if (rr_dist < 0) begin
        rr_dist = rr_dist + N;
      end
      if (req[j] && (rr_dist < rr_best)) begin
        rr_best   = rr_dist;
        rr_winner = ID_W'(j);
      end
    end
  end

  // Select the winner for the current mode, and decode its one-hot grant and its weight
  always_comb begin
    winner        = is_fixed ? fixed_winner : rr_winner;
    winner_onehot = '0;
    winner_weight = '0;
    for (int k = 0; k < N; k++) begin
      if (ID_W'(k) == winner) begin
        winner_onehot[k] = 1'b1;
        winner_weight    = weights[k*WEIGHT_W +: WEIGHT_W];
      end
    end
  end

  // Decide between holding the current owner and re-arbitrating, then compute the next state
  always_comb begin
    is_fixed  = (mode == 2'b00);
    is_wrr    = (mode == 2'b10);
    owner_req = |(req & grant_q);
`ifdef ARB_LOCK_EN
    lock_hold = lock && (state_q == GRANT) && owner_req;
`else
    lock_hold = 1'b0;
`endif
    hold_end  = !is_wrr || (credit_q == '0);
    arbitrate = (state_q == IDLE) || !owner_req || hold_end;

    state_d       = state_q;
    grant_d       = grant_q;
    grant_valid_d = grant_valid_q;
    grant_id_d    = grant_id_q;
    rr_ptr_d      = rr_ptr_q;
    credit_d      = credit_q;

    if (lock_hold) begin
      credit_d = credit_q;
    end else if (!arbitrate) begin
      credit_d = credit_q - WEIGHT_W'(1);
    end else if (req == '0) begin
      state_d       = IDLE;
      grant_d       = '0;
      grant_valid_d = 1'b0;
      grant_id_d    = '0;
      credit_d      = '0;
    end else begin
      state_d       = GRANT;
      grant_d       = winner_onehot;
      grant_valid_d = 1'b1;
      grant_id_d    = winner;
      rr_ptr_d      = winner;
      credit_d      = is_wrr ? winner_weight : '0;
    end
  end

  // State and registered outputs; the reset is asynchronous, and its release takes effect at the next clock edge
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      grant_q       <= '0;
      grant_valid_q <= 1'b0;
      grant_id_q    <= '0;
      rr_ptr_q      <= ID_W'(N - 1);
      credit_q      <= '0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      grant_valid_q <= grant_valid_d;
      grant_id_q    <= grant_id_d;
      rr_ptr_q      <= rr_ptr_d;
      credit_q      <= credit_d;
    end
  end

  assign grant       = grant_q;
  assign grant_valid = grant_valid_q;
  assign grant_id    = grant_id_q;

endmodule

// File: tb/tb_param_rr_arbiter.sv
// tb_param_rr_arbiter: directed and randomized self-checking bench for param_rr_arbiter.
// The reference model tracks the owner index, the round-robin pointer and the
// remaining burst credit as plain integers.
module tb_param_rr_arbiter;

  localparam int N   = 4;
  localparam int WW  = 3;
  localparam int IDW = 2;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [1:0]     mode = 2'b00;
  logic [N-1:0]   req = '0;
  logic [N*WW-1:0] weights = '0;
`ifdef ARB_LOCK_EN
  logic           lock = 1'b0;
`endif
  logic [N-1:0]   grant;
  logic           grant_valid;
  logic [IDW-1:0] grant_id;

  int checks = 0;
  int errors = 0;

  int w_arr [N];
  int m_owner;
  int m_ptr;
  int m_credit;
  logic [N-1:0] sampled_req;
  logic         m_lock;

  param_rr_arbiter #(.N(N), .WEIGHT_W(WW)) dut (
    .clk         (clk),
    .rst         (rst),
    .mode        (mode),
    .req         (req),
    .weights     (weights),
`ifdef ARB_LOCK_EN
    .lock        (lock),
`endif
    .grant       (grant),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  // Free-running clock
  always #5 clk = ~clk;

  function automatic bit bit_set(input logic [N-1:0] v, input int i);
    return ((v >> i) & N'(1)) != '0;
  endfunction

  function automatic logic [N-1:0] exp_grant();
    return (m_owner < 0) ? '0 : (N'(1) << m_owner);
  endfunction

  function automatic logic [IDW-1:0] exp_id();
    return (m_owner < 0) ? '0 : IDW'(m_owner);
  endfunction

  task automatic set_weights(input int w0, input int w1, input int w2, input int w3);
    w_arr[0] = w0; w_arr[1] = w1; w_arr[2] = w2; w_arr[3] = w3;
    weights = '0;
    for (int i = 0; i < N; i++) begin
      weights = weights | ((N*WW)'(w_arr[i] & ((1 << WW) - 1)) << (i * WW));
    end
  endtask

  task automatic model_reset();
    m_owner  = -1;
    m_ptr    = N - 1;
    m_credit = 0;
  endtask

  // One arbitration step, phrased directly in terms of owner, pointer and credit
  task automatic model_update(input logic [N-1:0] r, input logic [1:0] md, input logic lk);
    int win;
    bit owner_still;
    owner_still = (m_owner >= 0) && bit_set(r, m_owner);
    if (owner_still && lk) begin
      m_credit = m_credit;
    end else if (owner_still && md == 2'b10 && m_credit > 0) begin
      m_credit = m_credit - 1;
    end else if (r == '0) begin
      m_owner  = -1;
      m_credit = 0;
    end else begin
      win = -1;
      if (md == 2'b00) begin
        for (int i = N - 1; i >= 0 && win < 0; i--) if (bit_set(r, i)) win = i;
      end else begin
        for (int k = 1; k <= N && win < 0; k++) if (bit_set(r, (m_ptr + k) % N)) win = (m_ptr + k) % N;
      end
      m_owner  = win;
      m_ptr    = win;
      m_credit = (md == 2'b10) ? w_arr[win] : 0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
`ifdef ARB_LOCK_EN
    m_lock = lock;
`else
    m_lock = 1'b0;
`endif
    sampled_req = req;
    model_update(req, mode, m_lock);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    req  = 4'b1111;
    mode = 2'b00;
    #2 rst = 1'b0;
    model_reset();
    #1;
    checks++; if (grant !== 4'b0000) begin errors++; $display("[TB] FAIL reset_grant got=%b exp=0000", grant); end
    checks++; if (grant_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid got=%b exp=0", grant_valid); end
    checks++; if (grant_id !== 2'd0) begin errors++; $display("[TB] FAIL reset_id got=%0d exp=0", grant_id); end
    @(posedge clk); #1;
    checks++; if (grant !== 4'b0000) begin errors++; $display("[TB] FAIL reset_hold_grant got=%b exp=0000", grant); end
    @(negedge clk);
    rst  = 1'b1;
    mode = 2'b01;
    req  = 4'b0001;
    tick();
    checks++; if (grant !== 4'b0001) begin errors++; $display("[TB] FAIL pre_async_grant got=%b exp=0001", grant); end
    #2 rst = 1'b0;
    model_reset();
    #1;
    checks++; if (grant !== 4'b0000 || grant_valid !== 1'b0) begin errors++; $display("[TB] FAIL async_reset_mid got=%b/%b exp=0000/0", grant, grant_valid); end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_fixed();
    logic [N-1:0] reqs [4] = '{4'b1000, 4'b1110, 4'b0110, 4'b1111};
    logic [N-1:0] exps [4] = '{4'b1000, 4'b1000, 4'b0100, 4'b1000};
    mode = 2'b00;
    for (int i = 0; i < 4; i++) begin
      req = reqs[i];
      tick();
      checks++; if (grant !== exps[i]) begin errors++; $display("[TB] FAIL fixed_%0d got=%b exp=%b", i, grant, exps[i]); end
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (grant !== 4'b1000 || grant_id !== 2'd3) begin errors++; $display("[TB] FAIL fixed_hold_%0d got=%b id=%0d exp=1000 id=3", i, grant, grant_id); end
    end
  endtask

  task automatic test_round_robin();
    logic [N-1:0] exps [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    do_reset();
    mode = 2'b01;
    req  = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (grant !== exps[i]) begin errors++; $display("[TB] FAIL rr_%0d got=%b exp=%b", i, grant, exps[i]); end
    end
    req = 4'b0100;
    tick();
    checks++; if (grant !== 4'b0100 || grant_id !== 2'd2) begin errors++; $display("[TB] FAIL rr_single got=%b id=%0d exp=0100 id=2", grant, grant_id); end
    req = 4'b0000;
    tick();
    checks++; if (grant !== 4'b0000 || grant_valid !== 1'b0 || grant_id !== 2'd0) begin errors++; $display("[TB] FAIL rr_none got=%b v=%b id=%0d exp=0000 v=0 id=0", grant, grant_valid, grant_id); end
  endtask

  task automatic test_wrr();
    logic [N-1:0] exps [9] = '{4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0001};
    do_reset();
    set_weights(1, 2, 0, 0);
    mode = 2'b10;
    req  = 4'b1111;
    for (int i = 0; i < 9; i++) begin
      tick();
      checks++; if (grant !== exps[i]) begin errors++; $display("[TB] FAIL wrr_%0d got=%b exp=%b", i, grant, exps[i]); end
    end
  endtask

  task automatic test_early_release();
    do_reset();
    set_weights(3, 0, 0, 0);
    mode = 2'b10;
    req  = 4'b0011;
    tick();
    tick();
    checks++; if (grant !== 4'b0001) begin errors++; $display("[TB] FAIL early_hold got=%b exp=0001", grant); end
    req = 4'b0010;
    tick();
    checks++; if (grant !== 4'b0010 || grant_valid !== 1'b1) begin errors++; $display("[TB] FAIL early_release got=%b v=%b exp=0010 v=1", grant, grant_valid); end
  endtask

  task automatic test_mode_switch();
    do_reset();
    set_weights(3, 0, 0, 0);
    mode = 2'b10;
    req  = 4'b0011;
    tick();
    tick();
    mode = 2'b01;
    tick();
    checks++; if (grant !== 4'b0010) begin errors++; $display("[TB] FAIL mode_switch got=%b exp=0010", grant); end
  endtask

`ifdef ARB_LOCK_EN
  task automatic test_lock();
    do_reset();
    set_weights(0, 0, 0, 0);
    mode = 2'b10;
    req  = 4'b0011;
    tick();
    lock = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (grant !== 4'b0001) begin errors++; $display("[TB] FAIL lock_hold_%0d got=%b exp=0001", i, grant); end
    end
    lock = 1'b0;
    tick();
    checks++; if (grant !== 4'b0010) begin errors++; $display("[TB] FAIL lock_release got=%b exp=0010", grant); end
  endtask
`endif

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 600; c++) begin
      req = N'($urandom_range(0, (1 << N) - 1));
      if ($urandom_range(0, 3) == 0) req = grant;
      if ($urandom_range(0, 15) == 0) mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) set_weights($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7));
`ifdef ARB_LOCK_EN
      lock = ($urandom_range(0, 5) == 0);
`endif
      tick();
      checks++; if (grant !== exp_grant() || grant_valid !== (m_owner >= 0) || grant_id !== exp_id()) begin
        errors++; $display("[TB] FAIL random_%0d got=%b v=%b id=%0d exp=%b v=%b id=%0d", c, grant, grant_valid, grant_id, exp_grant(), (m_owner >= 0), exp_id());
      end
      checks++; if ((grant & ~sampled_req) !== '0 || !$onehot0(grant)) begin
        errors++; $display("[TB] FAIL random_invariant_%0d got=%b req=%b", c, grant, sampled_req);
      end
    end
`ifdef ARB_LOCK_EN
    lock = 1'b0;
`endif
  endtask

  initial begin
    set_weights(0, 0, 0, 0);
    model_reset();
    test_reset();
    test_fixed();
    test_round_robin();
    test_wrr();
    test_early_release();
    test_mode_switch();
`ifdef ARB_LOCK_EN
    test_lock();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
